// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: data width, iteration count,
// FSM state encoding and sign helpers.
package div_unit_pkg;

    localparam int unsigned DIV_DATA_WIDTH = 32;
    localparam int unsigned DIV_CYCLES_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        SIGN   = 2'd2,
        DONE   = 2'd3
    } div_state_t;

    // Magnitude of a two's-complement value; raw value for unsigned operations.
    function automatic logic [DIV_DATA_WIDTH-1:0] abs_if_signed(
        input logic [DIV_DATA_WIDTH-1:0] value,
        input logic                      is_signed
    );
        return (is_signed && value[DIV_DATA_WIDTH-1]) ? (~value + 1'b1) : value;
    endfunction

    function automatic logic [DIV_DATA_WIDTH-1:0] negate_if(
        input logic [DIV_DATA_WIDTH-1:0] value,
        input logic                      negate
    );
        return negate ? (~value + 1'b1) : value;
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference when it does not go negative.
module div_step
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DIV_DATA_WIDTH
) (
    input  logic [DATA_WIDTH:0]   partial_rem,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] next_rem,
    output logic                  quot_bit
);

    logic [DATA_WIDTH:0] diff;

    // partial_rem < 2*divisor, so bit DATA_WIDTH of diff is a reliable borrow.
    always_comb begin
        diff     = partial_rem - {1'b0, divisor};
        quot_bit = ~diff[DATA_WIDTH];
        next_rem = quot_bit ? diff[DATA_WIDTH-1:0] : partial_rem[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage: one restoring step per cycle,
// sign correction in a final cycle, results held until the next completion.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DIV_DATA_WIDTH,
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] operand_1,
    input  logic [DATA_WIDTH-1:0] operand_2,
    output logic                  stall_req,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic [DATA_WIDTH-1:0] result_lo
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_CYCLES - 1);

    div_state_t            state;
    logic [CNT_W-1:0]      iter_cnt;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] quot;
    logic [DATA_WIDTH-1:0] divisor_mag;
    logic                  quot_neg;
    logic                  rem_neg;

    logic [DATA_WIDTH-1:0] step_rem;
    logic                  step_bit;

    // The dividend is shifted out of quot's MSB as quotient bits shift in.
    div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div_step (
        .partial_rem (({rem, quot[DATA_WIDTH-1]})),
        .divisor     (divisor_mag),
        .next_rem    (step_rem),
        .quot_bit    (step_bit)
    );

    always_comb begin
        stall_req = rst_n &&
                    ((start && (state == IDLE) && !flush) ||
                     (state == DIVIDE) || (state == SIGN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            iter_cnt    <= '0;
            rem         <= '0;
            quot        <= '0;
            divisor_mag <= '0;
            quot_neg    <= 1'b0;
            rem_neg     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (operand_2 == '0) begin
                            result_lo <= '1;
                            result_hi <= operand_1;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            rem         <= '0;
                            quot        <= abs_if_signed(operand_1, is_signed);
                            divisor_mag <= abs_if_signed(operand_2, is_signed);
                            quot_neg    <= (operand_1[DATA_WIDTH-1] ^ operand_2[DATA_WIDTH-1]) & is_signed;
                            rem_neg     <= operand_1[DATA_WIDTH-1] & is_signed;
                            iter_cnt    <= '0;
                            busy        <= 1'b1;
                            state       <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    rem      <= step_rem;
                    quot     <= {quot[DATA_WIDTH-2:0], step_bit};
                    iter_cnt <= iter_cnt + 1'b1;
                    if (iter_cnt == LAST_ITER) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    result_lo <= negate_if(quot, quot_neg);
                    result_hi <= negate_if(rem, rem_neg);
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by
// zero, overflow case, flush and mid-operation reset.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic        flush;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] result_hi;
    logic [31:0] result_lo;

    int unsigned errors = 0;
    int unsigned checks = 0;

    div_unit #(
        .DATA_WIDTH (32),
        .DIV_CYCLES (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .flush     (flush),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result_hi (result_hi),
        .result_lo (result_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start in the current cycle (cycle 0); expects done in cycle 34.
    task automatic div_and_check(input string tag, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        start = 1'b1; is_signed = sgn; operand_1 = a; operand_2 = b;
        #1;
        chk({tag, "_stall_c0"}, {31'd0, stall_req}, 32'd1);
        tick();
        start = 1'b0; operand_1 = 32'hDEADBEEF; operand_2 = 32'h0;
        for (int k = 1; k < 34; k++) begin
            chk({tag, "_stall_run"}, {31'd0, stall_req}, 32'd1);
            chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
            chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
            tick();
        end
        chk({tag, "_done_c34"}, {31'd0, done}, 32'd1);
        chk({tag, "_lo"}, result_lo, exp_lo);
        chk({tag, "_hi"}, result_hi, exp_hi);
        chk({tag, "_stall_done"}, {31'd0, stall_req}, 32'd0);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        tick();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_lo_hold"}, result_lo, exp_lo);
        chk({tag, "_hi_hold"}, result_hi, exp_hi);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; is_signed = 1'b0; flush = 1'b0;
        operand_1 = 32'd100; operand_2 = 32'd7;
        #2;
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_lo", result_lo, 32'd0);
        chk("rst_hi", result_hi, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        div_and_check("udiv_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        div_and_check("sdiv_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        div_and_check("udiv_big", 1'b0, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF);
        div_and_check("sdiv_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);

        // Divide by zero, with start held into the DONE cycle (must not queue).
        start = 1'b1; is_signed = 1'b1; operand_1 = 32'h12345678; operand_2 = 32'h0;
        #1;
        chk("dz_stall_c0", {31'd0, stall_req}, 32'd1);
        tick();
        operand_1 = 32'd50; operand_2 = 32'd5;
        chk("dz_done_c1", {31'd0, done}, 32'd1);
        chk("dz_lo", result_lo, 32'hFFFFFFFF);
        chk("dz_hi", result_hi, 32'h12345678);
        chk("dz_stall_done", {31'd0, stall_req}, 32'd0);
        tick();
        start = 1'b0;
        chk("dz_done_pulse", {31'd0, done}, 32'd0);
        chk("dz_no_queue_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("dz_no_queue_busy2", {31'd0, busy}, 32'd0);
        chk("dz_lo_hold", result_lo, 32'hFFFFFFFF);

        div_and_check("sdiv_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);

        // Flush in cycle 10, restart in cycle 11 -> done in cycle 45.
        start = 1'b1; is_signed = 1'b0; operand_1 = 32'd1000; operand_2 = 32'd3;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        chk("fl_busy_c10", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        #1;
        chk("fl_stall_c10", {31'd0, stall_req}, 32'd1);
        tick();
        flush = 1'b0;
        chk("fl_busy_c11", {31'd0, busy}, 32'd0);
        chk("fl_done_c11", {31'd0, done}, 32'd0);
        chk("fl_lo_kept", result_lo, 32'h80000000);
        chk("fl_hi_kept", result_hi, 32'd0);
        div_and_check("fl_restart", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);

        // flush together with start in IDLE must not launch an operation.
        start = 1'b1; flush = 1'b1; operand_1 = 32'd9; operand_2 = 32'd0;
        #1;
        chk("flst_stall", {31'd0, stall_req}, 32'd0);
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flst_busy", {31'd0, busy}, 32'd0);
        chk("flst_done", {31'd0, done}, 32'd0);
        chk("flst_lo", result_lo, 32'd333);

        // Reset in cycle 20 of a division.
        start = 1'b1; is_signed = 1'b0; operand_1 = 32'd500; operand_2 = 32'd5;
        tick();
        start = 1'b0;
        for (int k = 1; k < 20; k++) tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_stall", {31'd0, stall_req}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_lo", result_lo, 32'd0);
        chk("mrst_hi", result_hi, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("mrst_no_done", {31'd0, done}, 32'd0);
        end
        chk("mrst_busy_after", {31'd0, busy}, 32'd0);
        chk("mrst_lo_after", result_lo, 32'd0);

        div_and_check("udiv_after_rst", 1'b0, 32'd77, 32'd77, 32'd1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
